flash_program_controller: RTL

//  Write-side companion to the paged-read ROM controller: issues Intel StrataFlash word-program and block-erase command sequences.

---
 rtl/flash_program_controller_pkg.sv | 40 ++++
 rtl/flash_program_controller_write_cycle.sv | 97 +++++++++
 rtl/flash_program_controller.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/flash_program_controller_pkg.sv
// Shared definitions for the StrataFlash program/erase controller:
// command codes, status-register bit positions, state encodings.
// Build option: FLASH_WRITE_VERIFY_EN adds a read-back VERIFY state.
package flash_program_controller_pkg;

    // Intel StrataFlash command codes (low byte of the data bus)
    localparam logic [7:0] CMD_PROGRAM    = 8'h40;
    localparam logic [7:0] CMD_ERASE      = 8'h20;
    localparam logic [7:0] CMD_CONFIRM    = 8'hD0;
    localparam logic [7:0] CMD_CLR_SR     = 8'h50;
    localparam logic [7:0] CMD_READ_ARRAY = 8'hFF;

    // Status-register bit indices
    localparam int unsigned SR_READY     = 7;
    localparam int unsigned SR_ERASE_ERR = 5;
    localparam int unsigned SR_PROG_ERR  = 4;
    localparam int unsigned SR_VPP_ERR   = 3;
    localparam int unsigned SR_LOCK_ERR  = 1;

`ifdef FLASH_WRITE_VERIFY_EN
    typedef enum logic [3:0] {
        StIdle, StWr1, StWr2, StPoll, StPollGap, StClr, StRdarr, StVerify, StDone
    } state_e;
`else
    typedef enum logic [3:0] {
        StIdle, StWr1, StWr2, StPoll, StPollGap, StClr, StRdarr, StDone
    } state_e;
`endif

    // Phases of one bus write cycle
    typedef enum logic [1:0] {
        PhIdle, PhSetup, PhPulse, PhHold
    } phase_e;

    // Any fault bit set in a completed status read
    function automatic logic sr_fault(input logic [7:0] sr);
        return sr[SR_ERASE_ERR] | sr[SR_PROG_ERR] | sr[SR_VPP_ERR] | sr[SR_LOCK_ERR];
    endfunction

endpackage

// File: rtl/flash_program_controller_write_cycle.sv
// One flash bus write cycle: SETUP (WE high, data driven), PULSE (WE low),
// HOLD (WE high, data still driven). cyc_done pulses in the last HOLD cycle;
// a start in that same cycle chains straight into the next write's SETUP.
module flash_program_controller_write_cycle
    import flash_program_controller_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned T_SETUP = 1,
    parameter int unsigned T_WE    = 3,
    parameter int unsigned T_HOLD  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             active,
    output logic             cyc_done,
    output logic             we_n,
    output logic             d_oe,
    output logic [WIDTH-1:0] d_out
);

    localparam logic [7:0] SetupLoad = 8'(T_SETUP - 1);
    localparam logic [7:0] WeLoad    = 8'(T_WE - 1);
    localparam logic [7:0] HoldLoad  = 8'(T_HOLD - 1);

    phase_e           phase_q, phase_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Phase register, phase counter and latched write word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= PhIdle;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // Phase sequencing
    always_comb begin
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        cyc_done = 1'b0;
        unique case (phase_q)
            PhIdle: begin
                if (start) begin
                    phase_d = PhSetup;
                    cnt_d   = SetupLoad;
                    data_d  = data;
                end
            end
            PhSetup: begin
                if (cnt_q == 8'd0) begin
                    phase_d = PhPulse;
                    cnt_d   = WeLoad;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            PhPulse: begin
                if (cnt_q == 8'd0) begin
                    phase_d = PhHold;
                    cnt_d   = HoldLoad;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            PhHold: begin
                if (cnt_q == 8'd0) begin
                    cyc_done = 1'b1;
                    if (start) begin
                        phase_d = PhSetup;
                        cnt_d   = SetupLoad;
                        data_d  = data;
                    end else begin
                        phase_d = PhIdle;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: phase_d = PhIdle;
        endcase
    end

    assign active = (phase_q != PhIdle);
    assign we_n   = (phase_q != PhPulse);
    assign d_oe   = active;
    assign d_out  = data_q;

endmodule

// File: rtl/flash_program_controller.sv
// StrataFlash word-program / block-erase sequencer. Issues the two command
// writes, polls the status register until ready, clears SR on a fault and
// always returns the part to read-array mode before pulsing done.
// Build option: FLASH_WRITE_VERIFY_EN reads the word back after a program
// and flags a miscompare as an error; erases never verify.
module flash_program_controller
    import flash_program_controller_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned ROM_ADDR = 23,
    parameter int unsigned T_SETUP  = 1,
    parameter int unsigned T_WE     = 3,
    parameter int unsigned T_HOLD   = 1,
    parameter int unsigned T_OE     = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ROM_ADDR-1:0] addr,
    input  logic [WIDTH-1:0]    wdata,
    input  logic                prog,
    input  logic                erase,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [7:0]          status,
    input  logic [WIDTH-1:0]    SF_D_in,
    output logic [WIDTH-1:0]    SF_D_out,
    output logic                SF_D_oe,
    output logic [ROM_ADDR:0]   SF_A,
    output logic                SF_CE0,
    output logic                SF_OE,
    output logic                SF_WE,
    output logic                SF_BYTE
);

    localparam logic [7:0] OeLoad = 8'(T_OE - 1);

    function automatic logic [WIDTH-1:0] cmd(input logic [7:0] c);
        return {{(WIDTH - 8){1'b0}}, c};
    endfunction

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [ROM_ADDR-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]    wdata_q, wdata_d;
    logic                is_erase_q, is_erase_d;
    logic                error_q, error_d;
    logic [7:0]          status_q, status_d;

    logic                wc_start, wc_active, wc_done, wc_we_n, wc_oe;
    logic [WIDTH-1:0]    wc_data, wc_out;
    logic                reading;

    // Sequencer state and operation context
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_erase_q <= 1'b0;
            error_q    <= 1'b0;
            status_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            is_erase_q <= is_erase_d;
            error_q    <= error_d;
            status_q   <= status_d;
        end
    end

    // Next-state, status sampling and write-cycle launch
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        is_erase_d = is_erase_q;
        error_d    = error_q;
        status_d   = status_q;
        unique case (state_q)
            StIdle: begin
                // prog has priority when both requests arrive together
                if (prog || erase) begin
                    addr_d     = addr;
                    wdata_d    = wdata;
                    is_erase_d = !prog;
                    error_d    = 1'b0;
                    state_d    = StWr1;
                end
            end
            StWr1: if (wc_done) state_d = StWr2;
            StWr2: begin
                if (wc_done) begin
                    state_d = StPoll;
                    cnt_d   = OeLoad;
                end
            end
            StPoll: begin
                if (cnt_q == 8'd0) begin
                    status_d = SF_D_in[7:0];
                    if (!SF_D_in[SR_READY]) begin
                        state_d = StPollGap;
                    end else if (sr_fault(SF_D_in[7:0])) begin
                        error_d = 1'b1;
                        state_d = StClr;
                    end else begin
                        state_d = StRdarr;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StPollGap: begin
                state_d = StPoll;
                cnt_d   = OeLoad;
            end
            StClr: if (wc_done) state_d = StRdarr;
`ifdef FLASH_WRITE_VERIFY_EN
            StRdarr: begin
                if (wc_done) begin
                    if (is_erase_q) begin
                        state_d = StDone;
                    end else begin
                        state_d = StVerify;
                        cnt_d   = OeLoad;
                    end
                end
            end
            StVerify: begin
                if (cnt_q == 8'd0) begin
                    if (SF_D_in != wdata_q) error_d = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
`else
            StRdarr: if (wc_done) state_d = StDone;
`endif
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Launch a write on the same edge the sequencer enters a write state
        wc_start = (state_d != state_q) && (state_d inside {StWr1, StWr2, StClr, StRdarr});
        case (state_d)
            StWr1:   wc_data = is_erase_d ? cmd(CMD_ERASE) : cmd(CMD_PROGRAM);
            StWr2:   wc_data = is_erase_q ? cmd(CMD_CONFIRM) : wdata_q;
            StClr:   wc_data = cmd(CMD_CLR_SR);
            StRdarr: wc_data = cmd(CMD_READ_ARRAY);
            default: wc_data = '0;
        endcase
    end

    flash_program_controller_write_cycle #(
        .WIDTH  (WIDTH),
        .T_SETUP(T_SETUP),
        .T_WE   (T_WE),
        .T_HOLD (T_HOLD)
    ) u_write_cycle (
        .clk     (clk),
        .reset   (reset),
        .start   (wc_start),
        .data    (wc_data),
        .active  (wc_active),
        .cyc_done(wc_done),
        .we_n    (wc_we_n),
        .d_oe    (wc_oe),
        .d_out   (wc_out)
    );

`ifdef FLASH_WRITE_VERIFY_EN
    assign reading = (state_q == StPoll) || (state_q == StVerify);
`else
    assign reading = (state_q == StPoll);
    logic unused_din;
    assign unused_din = ^SF_D_in[WIDTH-1:8];
`endif

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign error    = error_q;
    assign status   = status_q;
    assign SF_A     = {addr_q, 1'b0};
    assign SF_CE0   = !(wc_active || reading);
    assign SF_OE    = !reading;
    assign SF_WE    = wc_we_n;
    assign SF_D_oe  = wc_oe;
    assign SF_D_out = wc_out;
    assign SF_BYTE  = 1'b1;

endmodule
